// File: rtl/dispatch_pkg.sv
// Shared field layout, hazard-key helpers and core-select type for the
// dual-core instruction dispatcher.
package dispatch_pkg;

  // Instruction field positions
  localparam int PIN_BIT      = 27;
  localparam int CORE_BIT     = 26;
  localparam int SRC_FLAG_BIT = 23;
  localparam int DST_FLAG_BIT = 22;
  localparam int SRC_LSB      = 0;
  localparam int DST_LSB      = 11;
  localparam int REG_W        = 11;
  localparam int INSTR_W      = 32;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [REG_W:0]     hazard_key_t;

  typedef enum logic {
    CORE0 = 1'b0,
    CORE1 = 1'b1
  } core_sel_t;

  // Source key: flag bit prepended to the 11-bit source register id
  function automatic hazard_key_t src_key(input instr_t i);
    return {i[SRC_FLAG_BIT], i[SRC_LSB +: REG_W]};
  endfunction

  // Destination key: flag bit prepended to the 11-bit destination id
  function automatic hazard_key_t dst_key(input instr_t i);
    return {i[DST_FLAG_BIT], i[DST_LSB +: REG_W]};
  endfunction

  // Both flags set marks an instruction that never takes part in hazards
  function automatic logic no_hazard(input instr_t i);
    return i[SRC_FLAG_BIT] & i[DST_FLAG_BIT];
  endfunction

  // RAW, WAR and WAW between an incoming instruction and an in-flight entry
  function automatic logic conflicts(input instr_t incoming, input instr_t entry);
    logic hit;
    hit = (src_key(incoming) == dst_key(entry)) ||
          (dst_key(incoming) == src_key(entry)) ||
          (dst_key(incoming) == dst_key(entry));
    return hit & ~no_hazard(incoming) & ~no_hazard(entry);
  endfunction

endpackage

// File: rtl/dispatch_queue.sv
// Show-ahead FIFO for one core. Besides head/count/full it exposes every
// storage slot plus a per-slot valid mask so the dispatcher can scan the
// whole in-flight set for hazards in a single cycle.
module dispatch_queue
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 push,
  input  logic [INSTR_W-1:0]   push_data,
  input  logic                 pop,
  output logic [INSTR_W-1:0]   head,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic [DEPTH*INSTR_W-1:0] entries_flat,
  output logic [DEPTH-1:0]     entry_valid
);

  localparam int PW = $clog2(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic               do_push;
  logic               do_pop;

  // Refuse pushes to a full queue and pops from an empty one
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign head    = (count != '0) ? mem[rd_ptr] : '0;

  // Storage write; no reset needed since validity comes from the pointers
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below count
  always_comb begin
    logic [PW-1:0] off;
    off          = '0;
    entries_flat = '0;
    entry_valid  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      entries_flat[i*INSTR_W +: INSTR_W] = mem[i];
      entry_valid[i] = (CW'(off) < count);
    end
  end

endmodule

// File: rtl/dual_core_dispatcher.sv
// Dual-core instruction dispatcher. Accepts one instruction per cycle and
// steers it to core0 or core1 by pinning, then hazard affinity, then
// alternation, so that dependent instructions never run on both cores at
// once. Each core sees a show-ahead queue plus one busy slot that holds the
// instruction it is currently executing until it pulses done.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. in_ready is a function of registered state and in_instr
// only (never of in_valid or the core ready inputs); cX_valid is a function
// of registered state only.
module dual_core_dispatcher
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  input  logic [31:0]   in_instr,
  output logic          in_ready,
  output logic          c0_valid,
  output logic [31:0]   c0_instr,
  input  logic          c0_ready,
  input  logic          c0_done,
  output logic          c1_valid,
  output logic [31:0]   c1_instr,
  input  logic          c1_ready,
  input  logic          c1_done,
  output logic [CW-1:0] c0_count,
  output logic [CW-1:0] c1_count,
  output logic          hazard_stall
);

  // Queue interfaces
  logic [31:0]         q0_head, q1_head;
  logic [CW-1:0]       q0_count, q1_count;
  logic                q0_full, q1_full;
  logic [DEPTH*32-1:0] q0_flat, q1_flat;
  logic [DEPTH-1:0]    q0_vmask, q1_vmask;
  logic                push0, push1;
  logic                pop0, pop1;

  // Busy slots and alternation preference
  logic [31:0]         busy0, busy1;
  logic                busy0_valid, busy1_valid;
  core_sel_t           pref;

  // Routing decision
  logic                h0, h1;
  logic                pinned;
  core_sel_t           tgt;
  logic                route_ok;
  logic                dual_conflict;
  logic                accept;

  dispatch_queue #(.DEPTH(DEPTH), .CW(CW)) u_q0 (
    .clk          (clk),
    .resetn       (resetn),
    .push         (push0),
    .push_data    (in_instr),
    .pop          (pop0),
    .head         (q0_head),
    .count        (q0_count),
    .full         (q0_full),
    .entries_flat (q0_flat),
    .entry_valid  (q0_vmask)
  );

  dispatch_queue #(.DEPTH(DEPTH), .CW(CW)) u_q1 (
    .clk          (clk),
    .resetn       (resetn),
    .push         (push1),
    .push_data    (in_instr),
    .pop          (pop1),
    .head         (q1_head),
    .count        (q1_count),
    .full         (q1_full),
    .entries_flat (q1_flat),
    .entry_valid  (q1_vmask)
  );

  // Outputs are forced quiet while reset is held, even before the first edge
  assign c0_valid = resetn && (q0_count != '0);
  assign c1_valid = resetn && (q1_count != '0);
  assign c0_instr = resetn ? q0_head : '0;
  assign c1_instr = resetn ? q1_head : '0;
  assign c0_count = resetn ? q0_count : '0;
  assign c1_count = resetn ? q1_count : '0;

  assign pop0 = c0_valid && c0_ready;
  assign pop1 = c1_valid && c1_ready;

  // Conflict scan over each core's in-flight set as registered this cycle;
  // entries popped this cycle and unapplied done pulses still count
  always_comb begin
    h0 = busy0_valid && conflicts(in_instr, busy0);
    h1 = busy1_valid && conflicts(in_instr, busy1);
    for (int i = 0; i < DEPTH; i++) begin
      if (q0_vmask[i] && conflicts(in_instr, q0_flat[i*32 +: 32])) begin
        h0 = 1'b1;
      end
      if (q1_vmask[i] && conflicts(in_instr, q1_flat[i*32 +: 32])) begin
        h1 = 1'b1;
      end
    end
  end

  // Target selection: pinning, then hazard affinity, then preference
  always_comb begin
    pinned        = in_instr[PIN_BIT];
    tgt           = pref;
    route_ok      = 1'b0;
    dual_conflict = 1'b0;
    if (pinned) begin
      tgt      = core_sel_t'(in_instr[CORE_BIT]);
      route_ok = (tgt == CORE0) ? !q0_full : !q1_full;
    end else if (h0 && h1) begin
      dual_conflict = 1'b1;
    end else if (h0) begin
      tgt      = CORE0;
      route_ok = !q0_full;
    end else if (h1) begin
      tgt      = CORE1;
      route_ok = !q1_full;
    end else if ((pref == CORE0) ? !q0_full : !q1_full) begin
      tgt      = pref;
      route_ok = 1'b1;
    end else if ((pref == CORE0) ? !q1_full : !q0_full) begin
      tgt      = core_sel_t'(~pref);
      route_ok = 1'b1;
    end
  end

  assign in_ready     = resetn && route_ok;
  assign hazard_stall = resetn && in_valid && dual_conflict;
  assign accept       = in_valid && in_ready;
  assign push0        = accept && (tgt == CORE0);
  assign push1        = accept && (tgt == CORE1);

  // Alternation: the next unconstrained word prefers the other core
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pref <= CORE0;
    end else if (accept) begin
      pref <= core_sel_t'(~tgt);
    end
  end

  // Busy slots: a pop loads the slot and wins over a same-cycle done
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy0       <= '0;
      busy0_valid <= 1'b0;
      busy1       <= '0;
      busy1_valid <= 1'b0;
    end else begin
      if (pop0) begin
        busy0       <= q0_head;
        busy0_valid <= 1'b1;
      end else if (c0_done) begin
        busy0_valid <= 1'b0;
      end
      if (pop1) begin
        busy1       <= q1_head;
        busy1_valid <= 1'b1;
      end else if (c1_done) begin
        busy1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dual_core_dispatcher.sv
// Bench for dual_core_dispatcher: a directed vector table covering the
// routing, stall, fill and reset scenarios, followed by random traffic,
// with every cycle also compared against a queue-based reference model.
module tb_dual_core_dispatcher;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);
  localparam logic [31:0] FREE = 32'h00C0_0000;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          resetn;
  logic          in_valid;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          c0_valid, c1_valid;
  logic [31:0]   c0_instr, c1_instr;
  logic          c0_ready, c1_ready;
  logic          c0_done, c1_done;
  logic [CW-1:0] c0_count, c1_count;
  logic          hazard_stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dual_core_dispatcher #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .c0_valid     (c0_valid),
    .c0_instr     (c0_instr),
    .c0_ready     (c0_ready),
    .c0_done      (c0_done),
    .c1_valid     (c1_valid),
    .c1_instr     (c1_instr),
    .c1_ready     (c1_ready),
    .c1_done      (c1_done),
    .c0_count     (c0_count),
    .c1_count     (c1_count),
    .hazard_stall (hazard_stall)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  logic [31:0] mb0, mb1;
  bit          mb0v, mb1v;
  bit          mpref;

  function automatic bit m_pair(input logic [31:0] a, input logic [31:0] e);
    logic [11:0] as_k, ad_k, es_k, ed_k;
    if ((a[23] && a[22]) || (e[23] && e[22])) return 1'b0;
    as_k = {a[23], a[10:0]};
    ad_k = {a[22], a[21:11]};
    es_k = {e[23], e[10:0]};
    ed_k = {e[22], e[21:11]};
    return (as_k == ed_k) || (ad_k == es_k) || (ad_k == ed_k);
  endfunction

  function automatic bit m_conf(input logic [31:0] a, input bit core);
    logic [31:0] lst[$];
    bit hit;
    hit = 1'b0;
    if (core) begin
      lst = mq1;
      if (mb1v) lst.push_back(mb1);
    end else begin
      lst = mq0;
      if (mb0v) lst.push_back(mb0);
    end
    foreach (lst[k]) if (m_pair(a, lst[k])) hit = 1'b1;
    return hit;
  endfunction

  function automatic void m_route(input logic [31:0] a, output bit rdy, output bit t, output bit dual);
    bit f0, f1, h0, h1;
    f0 = (mq0.size() == DEPTH);
    f1 = (mq1.size() == DEPTH);
    rdy = 1'b0; t = mpref; dual = 1'b0;
    if (a[27]) begin
      t = a[26];
      rdy = t ? !f1 : !f0;
    end else begin
      h0 = m_conf(a, 1'b0);
      h1 = m_conf(a, 1'b1);
      if (h0 && h1) dual = 1'b1;
      else if (h0) begin t = 1'b0; rdy = !f0; end
      else if (h1) begin t = 1'b1; rdy = !f1; end
      else begin
        if (!(mpref ? f1 : f0)) begin t = mpref; rdy = 1'b1; end
        else if (!(mpref ? f0 : f1)) begin t = !mpref; rdy = 1'b1; end
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  bit m_t;
  bit m_rdy;

  // Drive one cycle's inputs and compare every output against the model
  task automatic drive(input bit rn, input bit v, input logic [31:0] a,
                       input bit r0, input bit r1, input bit d0, input bit d1);
    bit dual;
    resetn = rn; in_valid = v; in_instr = a;
    c0_ready = r0; c1_ready = r1; c0_done = d0; c1_done = d1;
    #1;
    m_route(a, m_rdy, m_t, dual);
    if (!rn) begin
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_stall", {31'd0, hazard_stall}, 32'd0);
      chk("rst_c0_valid", {31'd0, c0_valid}, 32'd0);
      chk("rst_c1_valid", {31'd0, c1_valid}, 32'd0);
      chk("rst_c0_instr", c0_instr, 32'd0);
      chk("rst_c1_instr", c1_instr, 32'd0);
      chk("rst_c0_count", 32'(c0_count), 32'd0);
      chk("rst_c1_count", 32'(c1_count), 32'd0);
    end else begin
      chk("m_ready", {31'd0, in_ready}, {31'd0, m_rdy});
      chk("m_stall", {31'd0, hazard_stall}, {31'd0, v && dual});
      chk("m_c0_valid", {31'd0, c0_valid}, {31'd0, mq0.size() != 0});
      chk("m_c1_valid", {31'd0, c1_valid}, {31'd0, mq1.size() != 0});
      chk("m_c0_instr", c0_instr, (mq0.size() != 0) ? mq0[0] : 32'd0);
      chk("m_c1_instr", c1_instr, (mq1.size() != 0) ? mq1[0] : 32'd0);
      chk("m_c0_count", 32'(c0_count), mq0.size());
      chk("m_c1_count", 32'(c1_count), mq1.size());
    end
  endtask

  // Apply the clock edge to the model, then move to the next falling edge
  task automatic advance();
    logic [31:0] tmp;
    if (!resetn) begin
      mq0.delete(); mq1.delete();
      mb0v = 1'b0; mb1v = 1'b0; mpref = 1'b0;
    end else begin
      if (c0_ready && mq0.size() != 0) begin
        tmp = mq0.pop_front(); mb0 = tmp; mb0v = 1'b1;
      end else if (c0_done) mb0v = 1'b0;
      if (c1_ready && mq1.size() != 0) begin
        tmp = mq1.pop_front(); mb1 = tmp; mb1v = 1'b1;
      end else if (c1_done) mb1v = 1'b0;
      if (in_valid && m_rdy) begin
        if (m_t) mq1.push_back(in_instr);
        else     mq0.push_back(in_instr);
        mpref = !m_t;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rn, v;
    logic [31:0] ins;
    bit          r0, r1, d0, d1;
    bit          e_rdy, e_st;
    int          e_c0, e_c1;
    bit          chk_h;
    logic [31:0] e_h0, e_h1;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit rn, input bit v, input logic [31:0] ins,
                              input bit r0, input bit r1, input bit d0, input bit d1,
                              input bit er, input bit es, input int c0, input int c1,
                              input bit ch, input logic [31:0] h0, input logic [31:0] h1);
    vec_t e;
    e.rn = rn; e.v = v; e.ins = ins; e.r0 = r0; e.r1 = r1; e.d0 = d0; e.d1 = d1;
    e.e_rdy = er; e.e_st = es; e.e_c0 = c0; e.e_c1 = c1;
    e.chk_h = ch; e.e_h0 = h0; e.e_h1 = h1;
    tbl.push_back(e);
  endfunction

  function automatic void build_table();
    // alternation after reset
    add(0,0,FREE,        0,0,0,0, 0,0,0,0, 1,0,0);
    add(1,1,32'h00008005,0,0,0,0, 1,0,0,0, 1,0,0);
    add(1,1,32'h00020003,0,0,0,0, 1,0,1,0, 0,0,0);
    add(1,0,FREE,        0,0,0,0, 1,0,1,1, 1,32'h00008005,32'h00020003);
    // dependent word follows its producer to core0
    add(0,0,FREE,        0,0,0,0, 0,0,0,0, 1,0,0);
    add(1,1,32'h00008005,0,0,0,0, 1,0,0,0, 0,0,0);
    add(1,1,32'h00010010,0,0,0,0, 1,0,1,0, 0,0,0);
    add(1,0,FREE,        0,0,0,0, 1,0,2,0, 1,32'h00008005,0);
    // dual-core conflict with busy slot and queued entry
    add(0,0,FREE,        0,0,0,0, 0,0,0,0, 0,0,0);
    add(1,1,32'h00008005,0,0,0,0, 1,0,0,0, 0,0,0);
    add(1,1,32'h00020003,0,0,0,0, 1,0,1,0, 0,0,0);
    add(1,0,FREE,        1,0,0,0, 1,0,1,1, 1,32'h00008005,32'h00020003);
    add(1,1,32'h00020010,0,0,0,0, 0,1,0,1, 1,0,32'h00020003);
    add(1,1,32'h00020010,0,0,1,0, 0,1,0,1, 0,0,0);
    add(1,0,FREE,        0,1,0,0, 1,0,0,1, 0,0,0);
    add(1,0,FREE,        0,0,0,1, 1,0,0,0, 0,0,0);
    add(1,1,32'h00020010,0,0,0,0, 1,0,0,0, 0,0,0);
    add(1,0,FREE,        0,0,0,0, 1,0,1,0, 1,32'h00020010,0);
    // pinned word bypasses hazards on both cores
    add(1,1,32'h00010010,0,0,0,0, 1,0,1,0, 0,0,0);
    add(1,1,32'h0C008005,0,0,0,0, 1,0,1,1, 0,0,0);
    add(1,0,FREE,        0,0,0,0, 1,0,1,2, 1,32'h00020010,32'h00010010);
    // fill core0 with pinned words
    add(0,0,FREE,        0,0,0,0, 0,0,0,0, 0,0,0);
    for (int i = 0; i < DEPTH; i++)
      add(1,1,32'h08000000,0,0,0,0, 1,0,i,0, 0,0,0);
    add(1,1,32'h08000000,0,0,0,0, 0,0,DEPTH,0, 0,0,0);
    add(1,1,FREE,        0,0,0,0, 1,0,DEPTH,0, 0,0,0);
    add(1,1,32'h08000000,1,0,0,0, 0,0,DEPTH,1, 1,32'h08000000,FREE);
    add(1,1,32'h08000000,0,0,0,0, 1,0,DEPTH-1,1, 0,0,0);
    add(1,0,FREE,        1,0,0,0, 1,0,DEPTH,1, 0,0,0);
    // reset with both queues occupied and a busy slot loaded
    add(0,0,FREE,        0,0,0,0, 0,0,0,0, 1,0,0);
    add(1,1,FREE,        0,0,0,0, 1,0,0,0, 0,0,0);
    add(1,0,FREE,        0,0,0,0, 1,0,1,0, 1,FREE,0);
    // busy slot was discarded: a word hazarding on it routes by preference
    add(1,1,32'h00000000,0,0,0,0, 1,0,1,0, 0,0,0);
    add(1,0,FREE,        0,0,0,0, 1,0,1,1, 1,FREE,32'h00000000);
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom();
    w[10:0]  = 11'($urandom_range(0, 3));
    w[21:11] = 11'($urandom_range(0, 3));
    w[23]    = ($urandom_range(0, 4) == 0);
    w[22]    = ($urandom_range(0, 4) == 0);
    w[27]    = ($urandom_range(0, 7) == 0);
    return w;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_instr = '0;
    c0_ready = 1'b0; c1_ready = 1'b0; c0_done = 1'b0; c1_done = 1'b0;
    mb0 = '0; mb1 = '0; mb0v = 1'b0; mb1v = 1'b0; mpref = 1'b0;
    build_table();
    @(negedge clk);

    foreach (tbl[i]) begin
      drive(tbl[i].rn, tbl[i].v, tbl[i].ins, tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1);
      chk($sformatf("tbl%0d_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d_stall", i), {31'd0, hazard_stall}, {31'd0, tbl[i].e_st});
      chk($sformatf("tbl%0d_c0_count", i), 32'(c0_count), tbl[i].e_c0);
      chk($sformatf("tbl%0d_c1_count", i), 32'(c1_count), tbl[i].e_c1);
      if (tbl[i].chk_h) begin
        chk($sformatf("tbl%0d_c0_instr", i), c0_instr, tbl[i].e_h0);
        chk($sformatf("tbl%0d_c1_instr", i), c1_instr, tbl[i].e_h1);
      end
      advance();
    end

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 3) != 0),
            rnd_instr(),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0));
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_core_dispatcher.md
Name: dual_core_dispatcher

Overview:
- Clocked instruction dispatcher in front of the two execution cores (core0, core1).
- Accepts one 32-bit instruction per cycle over a valid/ready handshake and routes it into one of two per-core show-ahead queues.
- Routing honours, in priority order: core pinning, register-hazard affinity, then alternating preference.
- Tracks in-flight work (queued entries plus one executing slot per core) so that dependent instructions never run concurrently on different cores.

Parameters:
- DEPTH, 8, entries per core queue (power of two, at least 2).
- CW, $clog2(DEPTH+1), width of the occupancy counters.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  reset
- in_valid  in  1  instruction offered
- in_instr  in  32  instruction word
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- c0_valid  out  1  core0 queue non-empty
- c0_instr  out  32  core0 queue head; 0 when empty
- c0_ready  in  1  core0 pops head when c0_valid && c0_ready
- c0_done  in  1  one-cycle pulse: core0 retired its executing instruction
- c1_valid, c1_instr, c1_ready, c1_done: same as core0, for core1
- c0_count, c1_count  out  CW  queue occupancy
- hazard_stall  out  1  in_valid is high and in_ready is low because of a dual-core conflict

Behaviour:
- Reset: resetn is synchronous, active-low.
  - Clears both queues and both busy slots; sets pref to core0.
  - While resetn=0: in_ready=0, cX_valid=0, cX_instr=0, counts=0, hazard_stall=0.
  - Reset mid-operation discards all queued and busy state; cores must also be reset.
- Instruction fields:
  - [27] pin.
  - [26] pinned core.
  - [23] src_flag, [10:0] src.
  - [22] dst_flag, [21:11] dst.
- Hazard keys:
  - S = {src_flag, src}, D = {dst_flag, dst} for the incoming instruction.
  - An entry E on core X conflicts with the incoming instruction if any of the following holds: S == E.D, D == E.S, or D == E.D.
  - If src_flag=1 and dst_flag=1, the instruction carries no hazard and conflicts with nothing.
- In-flight set of core X: all valid entries of queue X, plus busy_X.
  - busy_X is the instruction most recently popped by core X, held until cX_done.
- Hazard evaluation:
  - Evaluated combinationally from registered state at the start of the cycle.
  - An entry popped this cycle is still counted, and a done pulse arriving this cycle is not yet applied.
  - This is conservative by design.
- Routing (combinational, decided in the cycle of the handshake):
  1. pin=1: target = core in_instr[26]. Stall if that queue is full. No hazard check is applied.
  2. Otherwise, compute h0 and h1 (conflict with core0 / core1 in-flight sets).
  3. h0 && h1: stall, with hazard_stall=1.
  4. Exactly one of h0/h1 set: target = the conflicting core. Stall if that queue is full.
  5. Neither set: target = pref. If pref's queue is full and the other queue is not, target = the other core. If both queues are full, stall.
- On accept:
  - Push in_instr into the target queue.
  - pref <= opposite of the target (updated for pinned accepts too).
- Queues:
  - FIFO order, show-ahead.
  - Push and pop on the same queue in the same cycle are legal when full or empty-with-push.
    - Full queue with pop: the push is refused, because in_ready is computed from the registered count.
  - Count is unchanged on simultaneous push and pop.
  - Read and write pointers wrap modulo DEPTH.
- Busy slot:
  - Pop loads busy_X and sets busy_valid_X.
  - cX_done clears busy_valid_X.
  - Pop and done in the same cycle: the new instruction is loaded and the slot stays valid.
  - cX_done with no busy slot is ignored.
- Latency: an accepted instruction is visible at cX_instr the next cycle at the earliest.
- in_ready depends only on registered state and in_instr; it never depends on cX_ready.

Decomposition:
- dispatch_pkg:
  - Field bit-position constants.
  - 12-bit hazard_key_t type.
  - Functions src_key(), dst_key(), no_hazard().
  - Function conflicts(incoming, entry), returning 1 bit.
- Sub-module dispatch_queue (parameter DEPTH):
  - Show-ahead FIFO exposing head, count, full, and a flattened entry array with a per-entry valid mask for hazard scanning.
  - Instantiated twice.

Test Plan:
- Empty after reset. Send 0x0000_8005 (src 5, dst 0x10), then 0x0002_0003 (src 3, dst 0x40). Required: first goes to core0, second to core1 by alternation; c0_count=1, c1_count=1.
- Send 0x0000_8005, then dependent 0x0001_0010 (src 0x10, dst 0x20). Required: second goes to core0 despite pref=core1.
- core0 pops 0x0000_8005 (busy) and core1 holds 0x0002_0003 queued; then send 0x0002_0010 (src 0x10, dst 0x40). Required: conflicts with both cores, in_ready=0, hazard_stall=1. After a c0_done pulse the stall persists (conflict remains on core1); after core1 pops and pulses c1_done, it is accepted the next cycle.
- Pinned 0x0C00_8005 (pin=1, core1) while core1 holds a conflicting entry. Required: routed to core1 unconditionally.
- Fill core0 with DEPTH pinned 0x0800_0000 words. Required: c0_count=DEPTH, and a further core0-pinned word stalls with hazard_stall=0. A free 0x00C0_0000 word (both flags set, no hazard) goes to core1. Then pop one entry and confirm in_ready returns the following cycle.
- Assert resetn=0 for one cycle with both queues partially full and a busy slot set. Required: counts=0, cX_valid=0, cX_instr=0; the next free word goes to core0.
